// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port, 1-cycle-latency instruction memory between
// core fetch (F, read-only) and the boot/debug loader (L, read/write).
// During boot the loader owns the memory. Otherwise fetch has fixed priority,
// and a wait counter lets a starved loader win once after MAX_WAIT cycles.
// Optional feature macro: IMEM_ARB_WPROTECT_EN adds wp_i, which suppresses loader
// writes outside boot.
module imem_arbiter #(
  parameter int unsigned MEM_WORDS = 512,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         boot_i,
`ifdef IMEM_ARB_WPROTECT_EN
  input  logic                         wp_i,
`endif
  input  logic                         f_req_i,
  input  logic [31:0]                  f_addr_i,
  output logic                         f_gnt_o,
  output logic                         f_rvalid_o,
  output logic [31:0]                  f_rdata_o,
  output logic                         f_err_o,
  input  logic                         l_req_i,
  input  logic                         l_we_i,
  input  logic [31:0]                  l_addr_i,
  input  logic [31:0]                  l_wdata_i,
  output logic                         l_gnt_o,
  output logic                         l_rvalid_o,
  output logic [31:0]                  l_rdata_o,
  output logic                         l_err_o,
  output logic                         m_en_o,
  output logic                         m_we_o,
  output logic [$clog2(MEM_WORDS)-1:0] m_addr_o,
  output logic [31:0]                  m_wdata_o,
  input  logic [31:0]                  m_rdata_i
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {SrcNone, SrcF, SrcL} src_e;

  src_e          resp_src_q, resp_src_d;
  logic          resp_err_q, resp_err_d;
  logic          resp_we_q, resp_we_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;

  logic          wait_max;
  logic          acc;
  logic          acc_we;
  logic          acc_err;
  logic          wp_block;
  logic [31:0]   sel_addr;
  logic [31:0]   rdata_r;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(MEM_WORDS));
  endfunction

  assign wait_max = (wait_cnt_q == WW'(MAX_WAIT));

  // Grant selection; gated by rst_n so every output is low while in reset.
  always_comb begin
    f_gnt_o = 1'b0;
    l_gnt_o = 1'b0;
    if (rst_n) begin
      if (boot_i) begin
        l_gnt_o = l_req_i;
      end else if (l_req_i && wait_max) begin
        l_gnt_o = 1'b1;
      end else if (f_req_i) begin
        f_gnt_o = 1'b1;
      end else begin
        l_gnt_o = l_req_i;
      end
    end
  end

`ifdef IMEM_ARB_WPROTECT_EN
  assign wp_block = wp_i & ~boot_i & l_gnt_o & l_we_i;
`else
  assign wp_block = 1'b0;
`endif

  // Decode the accepted access and drive the memory in the same cycle.
  always_comb begin
    acc       = f_gnt_o | l_gnt_o;
    sel_addr  = l_gnt_o ? l_addr_i : f_addr_i;
    acc_we    = l_gnt_o & l_we_i;
    // Fetch during boot can never be granted; kept as an error for safety.
    acc_err   = acc & (addr_bad(sel_addr) | (f_gnt_o & boot_i) | wp_block);
    m_en_o    = acc & ~acc_err;
    m_we_o    = m_en_o & acc_we;
    m_addr_o  = acc ? sel_addr[AW+1:2] : '0;
    m_wdata_o = (m_en_o && acc_we) ? l_wdata_i : 32'h0;
  end

  // Next-state for response tracking and the loader starvation counter.
  always_comb begin
    resp_src_d = l_gnt_o ? SrcL : (f_gnt_o ? SrcF : SrcNone);
    resp_err_d = acc_err;
    resp_we_d  = acc_we;
    if (l_req_i && !l_gnt_o) begin
      wait_cnt_d = wait_max ? wait_cnt_q : wait_cnt_q + WW'(1);
    end else begin
      wait_cnt_d = '0;
    end
  end

  // State registers; reset drops any response in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_src_q <= SrcNone;
      resp_err_q <= 1'b0;
      resp_we_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      resp_src_q <= resp_src_d;
      resp_err_q <= resp_err_d;
      resp_we_q  <= resp_we_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Route the response to its originator; writes and errors return zero data.
  always_comb begin
    rdata_r    = (resp_err_q || resp_we_q) ? 32'h0 : m_rdata_i;
    f_rvalid_o = (resp_src_q == SrcF);
    l_rvalid_o = (resp_src_q == SrcL);
    f_rdata_o  = f_rvalid_o ? rdata_r : 32'h0;
    l_rdata_o  = l_rvalid_o ? rdata_r : 32'h0;
    f_err_o    = f_rvalid_o & resp_err_q;
    l_err_o    = l_rvalid_o & resp_err_q;
  end

endmodule
